bus_controller_8288: RTL and testbench

- Cycle-level replacement for the 8288 bus controller. Sits between the 8088 status outputs and the ready generator.
- Decodes the CPU status lines s2..s0 into ALE, the memory/IO/INTA command strobes and the data-buffer controls.
- Its io_read_n, io_write_n and memory_read_n outputs feed the ready generator. It consumes processor_ready from that block to stretch T3 into wait states.
- Runs on the fast system clock. The CPU clock arrives as a sampled level, and the block edge-detects it internally.

---
 rtl/bus_controller_8288.sv | 204 ++++++++++++++++++++
 tb/tb_bus_controller_8288.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_controller_8288.sv
// -----------------------------------------------------------------------------
// bus_controller_8288
//
// Cycle-level replacement for the 8288 bus controller. Runs on the fast system
// clock, edge-detects the sampled CPU clock level and walks the 8088 bus cycle
// (T1..T4 plus wait states). It decodes s2..s0 into ALE, one command strobe and
// the data transceiver controls.
//
// Parameters
//   ADVANCED_WRITE  0: write commands assert at T3 entry; 1: at T2 entry.
//
// Ports
//   clock                    system clock
//   reset                    asynchronous, active-high
//   cpu_clock                CPU clock level, synchronous to clock
//   processor_status[2:0]    8088 s2..s0, 3'b111 = passive
//   processor_ready          registered READY, 1 = no wait state
//   address_enable_n         0 = CPU owns bus, 1 = commands disabled
//   address_latch_enable     ALE
//   io_read_n                IORC
//   io_write_n               IOWC
//   memory_read_n            MRDC
//   memory_write_n           MWTC
//   interrupt_acknowledge_n  INTA
//   data_enable              DEN, 1 = data transceiver enabled
//   data_transmit_receive_n  DT/R, 0 = receive
// -----------------------------------------------------------------------------
module bus_controller_8288 #(
    parameter bit ADVANCED_WRITE = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cpu_clock,
    input  logic [2:0] processor_status,
    input  logic       processor_ready,
    input  logic       address_enable_n,
    output logic       address_latch_enable,
    output logic       io_read_n,
    output logic       io_write_n,
    output logic       memory_read_n,
    output logic       memory_write_n,
    output logic       interrupt_acknowledge_n,
    output logic       data_enable,
    output logic       data_transmit_receive_n
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_TW,
        ST_T4
    } state_t;

    localparam logic [2:0] STS_INTA       = 3'b000;
    localparam logic [2:0] STS_IO_READ    = 3'b001;
    localparam logic [2:0] STS_IO_WRITE   = 3'b010;
    localparam logic [2:0] STS_HALT       = 3'b011;
    localparam logic [2:0] STS_CODE_FETCH = 3'b100;
    localparam logic [2:0] STS_MEM_READ   = 3'b101;
    localparam logic [2:0] STS_MEM_WRITE  = 3'b110;
    localparam logic [2:0] STS_PASSIVE    = 3'b111;

    function automatic logic is_read(input logic [2:0] sts);
        return sts inside {STS_INTA, STS_IO_READ, STS_CODE_FETCH, STS_MEM_READ};
    endfunction

    function automatic logic is_write(input logic [2:0] sts);
        return sts inside {STS_IO_WRITE, STS_MEM_WRITE};
    endfunction

    state_t     state_q, state_d;
    logic [2:0] cycle_type_q, cycle_type_d;
    logic [2:0] prev_status_q;
    logic       prev_cpu_clock_q;
    logic       ale_q, ale_d;
    logic       cmd_q, cmd_d;      // the single command selected by cycle_type_q
    logic       den_q, den_d;
    logic       dtr_q, dtr_d;

    logic cpu_rise;
    logic cpu_fall;
    logic start_ok;

    assign cpu_rise = ~prev_cpu_clock_q & cpu_clock;
    assign cpu_fall = prev_cpu_clock_q & ~cpu_clock;

    // A new cycle needs a passive status at the previous CPU posedge, so a
    // status that changes directly from one active code to another is ignored.
    assign start_ok = (processor_status != STS_PASSIVE) &&
                      (prev_status_q == STS_PASSIVE) &&
                      !address_enable_n;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            cycle_type_q     <= STS_PASSIVE;
            prev_status_q    <= STS_PASSIVE;
            prev_cpu_clock_q <= 1'b0;
            ale_q            <= 1'b0;
            cmd_q            <= 1'b0;
            den_q            <= 1'b0;
            dtr_q            <= 1'b1;
        end else begin
            state_q          <= state_d;
            cycle_type_q     <= cycle_type_d;
            prev_cpu_clock_q <= cpu_clock;
            if (cpu_rise) begin
                prev_status_q <= processor_status;
            end
            ale_q <= ale_d;
            cmd_q <= cmd_d;
            den_q <= den_d;
            dtr_q <= dtr_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        cycle_type_d = cycle_type_q;
        ale_d        = ale_q;
        cmd_d        = cmd_q;
        den_d        = den_q;
        dtr_d        = dtr_q;

        case (state_q)
            ST_IDLE, ST_T4: begin
                if (cpu_rise) begin
                    if (start_ok) begin
                        state_d      = ST_T1;
                        cycle_type_d = processor_status;
                        ale_d        = 1'b1;
                        dtr_d        = ~is_read(processor_status);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_T1: begin
                if (cpu_fall) begin
                    ale_d = 1'b0;
                end
                if (cpu_rise) begin
                    ale_d = 1'b0;
                    if (cycle_type_q == STS_HALT) begin
                        state_d = ST_IDLE;
                        dtr_d   = 1'b1;
                    end else begin
                        state_d = ST_T2;
                        den_d   = 1'b1;
                        cmd_d   = is_read(cycle_type_q) |
                                  (ADVANCED_WRITE & is_write(cycle_type_q));
                    end
                end
            end

            ST_T2: begin
                if (cpu_rise) begin
                    state_d = ST_T3;
                    if (!ADVANCED_WRITE && is_write(cycle_type_q)) begin
                        cmd_d = 1'b1;
                    end
                end
            end

            ST_T3, ST_TW: begin
                if (cpu_rise) begin
                    if (processor_ready) begin
                        state_d = ST_T4;
                        cmd_d   = 1'b0;
                        den_d   = 1'b0;
                        dtr_d   = 1'b1;
                    end else begin
                        state_d = ST_TW;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Bus grant gating is combinational so a DMA takeover disables the strobes
    // immediately; the FSM itself keeps running to the end of the cycle.
    logic cmd_on;
    assign cmd_on = cmd_q & ~address_enable_n;

    assign address_latch_enable    = ale_q & ~address_enable_n;
    assign io_read_n               = ~(cmd_on && cycle_type_q == STS_IO_READ);
    assign io_write_n              = ~(cmd_on && cycle_type_q == STS_IO_WRITE);
    assign memory_read_n           = ~(cmd_on && (cycle_type_q == STS_CODE_FETCH ||
                                                  cycle_type_q == STS_MEM_READ));
    assign memory_write_n          = ~(cmd_on && cycle_type_q == STS_MEM_WRITE);
    assign interrupt_acknowledge_n = ~(cmd_on && cycle_type_q == STS_INTA);
    assign data_enable             = den_q & ~address_enable_n;
    assign data_transmit_receive_n = dtr_q;

endmodule

// File: tb/tb_bus_controller_8288.sv
// -----------------------------------------------------------------------------
// tb_bus_controller_8288
//
// Drives two instances (ADVANCED_WRITE = 0 and 1) with the same bus cycles.
// Stimulus advances in CPU half-phases; for each half-phase a timeline model
// computes the expected output vector and queues it whenever it changes. A
// monitor pops an entry each time a DUT's output vector changes and compares
// both the vector and the half-phase in which the change happened.
//
// Output vector: {ALE, IORC_n, IOWC_n, MRDC_n, MWTC_n, INTA_n, DEN, DT/R}
// -----------------------------------------------------------------------------
module tb_bus_controller_8288;

    localparam int          HALF     = 4;            // system clocks per CPU half-phase
    localparam logic [7:0]  IDLE_VEC = 8'b0111_1101;

    logic       clock = 1'b0;
    logic       reset;
    logic       cpu_clock;
    logic [2:0] processor_status;
    logic       processor_ready;
    logic       address_enable_n;

    logic [1:0] ale, iorc_n, iowc_n, mrdc_n, mwtc_n, inta_n, den, dtr_n;
    logic [7:0] dut_vec [2];

    always #5 clock = ~clock;

    bus_controller_8288 #(.ADVANCED_WRITE(1'b0)) dut0 (
        .clock                  (clock),
        .reset                  (reset),
        .cpu_clock              (cpu_clock),
        .processor_status       (processor_status),
        .processor_ready        (processor_ready),
        .address_enable_n       (address_enable_n),
        .address_latch_enable   (ale[0]),
        .io_read_n              (iorc_n[0]),
        .io_write_n             (iowc_n[0]),
        .memory_read_n          (mrdc_n[0]),
        .memory_write_n         (mwtc_n[0]),
        .interrupt_acknowledge_n(inta_n[0]),
        .data_enable            (den[0]),
        .data_transmit_receive_n(dtr_n[0])
    );

    bus_controller_8288 #(.ADVANCED_WRITE(1'b1)) dut1 (
        .clock                  (clock),
        .reset                  (reset),
        .cpu_clock              (cpu_clock),
        .processor_status       (processor_status),
        .processor_ready        (processor_ready),
        .address_enable_n       (address_enable_n),
        .address_latch_enable   (ale[1]),
        .io_read_n              (iorc_n[1]),
        .io_write_n             (iowc_n[1]),
        .memory_read_n          (mrdc_n[1]),
        .memory_write_n         (mwtc_n[1]),
        .interrupt_acknowledge_n(inta_n[1]),
        .data_enable            (den[1]),
        .data_transmit_receive_n(dtr_n[1])
    );

    assign dut_vec[0] = {ale[0], iorc_n[0], iowc_n[0], mrdc_n[0], mwtc_n[0], inta_n[0], den[0], dtr_n[0]};
    assign dut_vec[1] = {ale[1], iorc_n[1], iowc_n[1], mrdc_n[1], mwtc_n[1], inta_n[1], den[1], dtr_n[1]};

    typedef struct {
        int         phase;
        logic [7:0] vec;
    } exp_t;

    exp_t       exp_q [2][$];
    logic [7:0] last_push [2];
    logic [7:0] last_seen [2];
    int         phase;
    bit         mon_en;
    int         checks;
    int         errors;

    task automatic check(input string name, input bit ok, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Timeline model of one bus cycle, in CPU half-phases counted from the
    // posedge that starts T1 (offset 0). T2 starts at 2, T3 at 4, and T4 at
    // 6 + 2*waits.
    function automatic logic [7:0] model(input bit adv, input logic [2:0] ty, input int w,
                                         input int o, input bit aen, input bit after_reset);
        bit rd, wr, halt, a, c, d, t;
        int t4, cstart;
        if (after_reset) return IDLE_VEC;
        rd     = ty inside {3'd0, 3'd1, 3'd4, 3'd5};
        wr     = ty inside {3'd2, 3'd6};
        halt   = (ty == 3'd3);
        t4     = 6 + 2 * w;
        cstart = (wr && !adv) ? 4 : 2;
        a = (o == 0);
        t = !(rd && o < t4);
        d = !halt && o >= 2 && o < t4;
        c = (rd || wr) && o >= cstart && o < t4;
        if (aen) begin
            a = 1'b0;
            c = 1'b0;
            d = 1'b0;
        end
        return {a, !(c && ty == 3'd1), !(c && ty == 3'd2), !(c && (ty == 3'd4 || ty == 3'd5)),
                !(c && ty == 3'd6), !(c && ty == 3'd0), d, t};
    endfunction

    // One CPU half-phase: apply inputs, toggle the CPU clock, queue expectations.
    task automatic drive_phase(input logic [2:0] st, input logic rdy, input logic aen,
                               input bit rst_pulse, input logic [7:0] e0, input logic [7:0] e1);
        exp_t item;
        @(posedge clock);
        #1;
        processor_status = st;
        processor_ready  = rdy;
        address_enable_n = aen;
        cpu_clock        = ~cpu_clock;
        phase++;
        if (rst_pulse) reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            item.phase = phase;
            item.vec   = (k == 0) ? e0 : e1;
            if (item.vec !== last_push[k]) begin
                exp_q[k].push_back(item);
                last_push[k] = item.vec;
            end
        end
        if (rst_pulse) begin
            repeat (2) @(posedge clock);
            #1 reset = 1'b0;
            repeat (HALF - 3) @(posedge clock);
        end else begin
            repeat (HALF - 1) @(posedge clock);
        end
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < 2 * n; i++)
            drive_phase(3'b111, 1'($urandom_range(0, 1)), 1'b0, 1'b0, IDLE_VEC, IDLE_VEC);
    endtask

    // Active status presented while the bus is granted away: no cycle may start.
    task automatic no_start(input logic [2:0] ty);
        for (int i = 0; i < 2; i++)
            drive_phase(ty, 1'($urandom_range(0, 1)), 1'b1, 1'b0, IDLE_VEC, IDLE_VEC);
    endtask

    // Full bus cycle. aen_rise grants the bus away from the TW negedge through
    // the T4 posedge; rst_tw pulses reset in the TW negedge half-phase.
    task automatic run_cycle(input logic [2:0] ty, input int w, input bit aen_rise,
                             input bit rst_tw, output bit can_chain);
        bit   halt;
        int   len;
        logic [2:0] st;
        logic rdy, aen;
        bit   rp, tail;
        halt = (ty == 3'd3);
        len  = halt ? 2 : 8 + 2 * w;
        for (int o = 0; o < len; o++) begin
            if (o < 2)      st = ty;
            else if (o < 4) st = 3'($urandom_range(0, 6));   // must be ignored
            else            st = 3'b111;
            rdy = 1'($urandom_range(0, 1));
            if (o >= 6 && (o % 2) == 0 && (o - 6) / 2 <= w) rdy = ((o - 6) / 2 == w);
            aen  = aen_rise && o >= 7 && o <= 6 + 2 * w;
            rp   = rst_tw && o == 7;
            tail = rst_tw && o >= 7;
            drive_phase(st, rdy, aen, rp, model(1'b0, ty, w, o, aen, tail),
                        model(1'b1, ty, w, o, aen, tail));
            if (rp) break;
        end
        can_chain = !halt && !rst_tw;
    endtask

    // Monitor: pops one expectation for every observed change of a DUT's outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                for (int k = 0; k < 2; k++) begin
                    if (dut_vec[k] !== last_seen[k]) begin
                        last_seen[k] = dut_vec[k];
                        if (exp_q[k].size() == 0) begin
                            check($sformatf("dut%0d_unexpected_change", k), 1'b0,
                                  $sformatf("got vec %b in phase %0d, expected no change",
                                            dut_vec[k], phase));
                        end else begin
                            e = exp_q[k].pop_front();
                            check($sformatf("dut%0d_output", k),
                                  e.phase == phase && e.vec === dut_vec[k],
                                  $sformatf("got phase %0d vec %b, expected phase %0d vec %b",
                                            phase, dut_vec[k], e.phase, e.vec));
                        end
                    end
                end
            end
        end
    end

    initial begin
        bit         can;
        logic [2:0] ty;
        int         w;
        bit         ar, rs;

        checks           = 0;
        errors           = 0;
        phase            = 0;
        mon_en           = 1'b0;
        reset            = 1'b1;
        cpu_clock        = 1'b0;
        processor_status = 3'b111;
        processor_ready  = 1'b1;
        address_enable_n = 1'b0;
        last_push[0]     = IDLE_VEC;
        last_push[1]     = IDLE_VEC;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("dut%0d_reset_state", k), dut_vec[k] === IDLE_VEC,
                  $sformatf("got %b, expected %b", dut_vec[k], IDLE_VEC));
            last_seen[k] = dut_vec[k];
        end
        mon_en = 1'b1;
        idle_gap(1);

        // Directed cycles.
        run_cycle(3'b001, 0, 1'b0, 1'b0, can); idle_gap(1);   // IO read, no waits
        run_cycle(3'b110, 1, 1'b0, 1'b0, can); idle_gap(1);   // memory write, one wait
        run_cycle(3'b110, 0, 1'b0, 1'b0, can); idle_gap(1);   // memory write, no waits
        run_cycle(3'b000, 0, 1'b0, 1'b0, can);                // INTA ...
        run_cycle(3'b100, 0, 1'b0, 1'b0, can); idle_gap(1);   // ... chained code fetch
        no_start(3'b101); idle_gap(1);                        // bus granted away
        run_cycle(3'b010, 1, 1'b1, 1'b0, can); idle_gap(1);   // IO write, AEN rises in TW
        run_cycle(3'b101, 1, 1'b0, 1'b1, can); idle_gap(1);   // memory read, reset in TW
        run_cycle(3'b011, 0, 1'b0, 1'b0, can); idle_gap(1);   // halt

        // Randomised cycles.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                no_start(3'($urandom_range(0, 6)));
                idle_gap(1);
                continue;
            end
            ty = 3'($urandom_range(0, 6));
            w  = $urandom_range(0, 2);
            ar = (w >= 1) && (ty != 3'd3) && ($urandom_range(0, 4) == 0);
            rs = !ar && (w >= 1) && (ty != 3'd3) && ($urandom_range(0, 7) == 0);
            run_cycle(ty, w, ar, rs, can);
            if (!can || $urandom_range(0, 1) == 1) idle_gap($urandom_range(1, 2));
        end

        idle_gap(2);
        for (int k = 0; k < 2; k++)
            check($sformatf("dut%0d_drain", k), exp_q[k].size() == 0,
                  $sformatf("got %0d pending expectations, expected 0", exp_q[k].size()));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
